step_sequencer: RTL and testbench

- Sequences one Pac-Man game step per game_tick pulse from the 2 Hz game clock.
- Issues one-cycle start pulses, in fixed order, to the Pac-Man mover, each ghost mover and the collision checker. Waits for each unit's done before starting the next, so the units take turns on the shared maze RAM read port.
- Also owns the frightened-mode timer and the step counter.

---
 rtl/step_sequencer.sv | 170 +++++++++++++++++
 tb/tb_step_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_sequencer.sv
// step_sequencer
//   Runs one Pac-Man game step per game_tick. Each step hands the shared
//   maze RAM read port to one unit at a time: the Pac-Man mover first, then
//   each ghost mover in ascending index order, then the collision checker.
//   Each unit gets a one-cycle go pulse, and the next unit starts only after
//   the current one reports done. The block also owns the frightened-mode
//   timer and the completed-step counter.
//
// Ports
//   Clk, Reset        50 MHz clock, asynchronous active-high reset
//   game_tick         one-cycle pulse per game step
//   pause             level; blocks the start of new steps
//   power_pellet      one-cycle pulse; reloads the frightened timer
//   pac_done          Pac-Man mover finished
//   ghost_done[i]     ghost mover i finished
//   coll_done         collision checker finished
//   pac_go            start pulse to the Pac-Man mover
//   ghost_go[i]       one-hot start pulse to ghost mover i
//   coll_go           start pulse to the collision checker
//   step_busy         a step is in progress
//   frightened        frightened timer is nonzero
//   overrun           sticky; a tick arrived while a step was running
//   timeout_err       sticky; a unit never answered and was forced done
//   step_count        completed steps, wraps at 16 bits
module step_sequencer #(
    parameter int NUM_GHOSTS   = 4,
    parameter int FRIGHT_TICKS = 16,
    parameter int STEP_TIMEOUT = 1024
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  game_tick,
    input  logic                  pause,
    input  logic                  power_pellet,
    input  logic                  pac_done,
    input  logic [NUM_GHOSTS-1:0] ghost_done,
    input  logic                  coll_done,
    output logic                  pac_go,
    output logic [NUM_GHOSTS-1:0] ghost_go,
    output logic                  coll_go,
    output logic                  step_busy,
    output logic                  frightened,
    output logic                  overrun,
    output logic                  timeout_err,
    output logic [15:0]           step_count
);
    localparam int GW = (NUM_GHOSTS > 1) ? $clog2(NUM_GHOSTS) : 1;
    localparam int TW = (STEP_TIMEOUT > 2) ? $clog2(STEP_TIMEOUT) : 1;
    localparam int FW = $clog2(FRIGHT_TICKS + 1);

    localparam logic [GW-1:0] LAST_GHOST = GW'(NUM_GHOSTS - 1);
    // The counter reads 0 in the first wait cycle, so this value is seen in
    // wait cycle STEP_TIMEOUT-1, the cycle in which the counter would reach
    // STEP_TIMEOUT-1.
    localparam logic [TW-1:0] TO_LAST    = TW'(STEP_TIMEOUT - 2);
    localparam logic [FW-1:0] FR_LOAD    = FW'(FRIGHT_TICKS);

    typedef enum logic [2:0] {
        IDLE, PAC_GO, PAC_WAIT, GHOST_SEL, GHOST_WAIT, COLL_GO, COLL_WAIT, FINISH
    } state_t;

    state_t                  state, state_nxt;
    logic [GW-1:0]           gidx, gidx_nxt;
    logic [TW-1:0]           to_cnt;
    logic [FW-1:0]           fright_cnt, fright_nxt;
    logic [15:0]             step_count_nxt;
    logic [NUM_GHOSTS-1:0]   ghost_go_nxt;
    logic                    in_wait, to_hit, to_set;

    assign in_wait = (state == PAC_WAIT) || (state == GHOST_WAIT) || (state == COLL_WAIT);
    assign to_hit  = in_wait && (to_cnt == TO_LAST);

    // Next state and ghost index. A timeout counts as done; to_set marks
    // the cases where it was the timeout and not the unit that finished.
    always_comb begin
        state_nxt = state;
        gidx_nxt  = gidx;
        to_set    = 1'b0;
        unique case (state)
            IDLE:       if (game_tick && !pause) state_nxt = PAC_GO;
            PAC_GO:     state_nxt = PAC_WAIT;
            PAC_WAIT: begin
                if (pac_done || to_hit) begin
                    state_nxt = GHOST_SEL;
                    gidx_nxt  = '0;
                    to_set    = !pac_done;
                end
            end
            GHOST_SEL: begin
                // ghost_go holds this cycle's pulse; none means the ghost is
                // being skipped.
                if (|ghost_go)                state_nxt = GHOST_WAIT;
                else if (gidx == LAST_GHOST)  state_nxt = COLL_GO;
                else                          gidx_nxt  = gidx + GW'(1);
            end
            GHOST_WAIT: begin
                if (ghost_done[gidx] || to_hit) begin
                    to_set = !ghost_done[gidx];
                    if (gidx == LAST_GHOST) begin
                        state_nxt = COLL_GO;
                    end else begin
                        state_nxt = GHOST_SEL;
                        gidx_nxt  = gidx + GW'(1);
                    end
                end
            end
            COLL_GO:    state_nxt = COLL_WAIT;
            COLL_WAIT: begin
                if (coll_done || to_hit) begin
                    state_nxt = FINISH;
                    to_set    = !coll_done;
                end
            end
            FINISH:     state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Timer, counter and the registered go pulses. The go pulse for a ghost
    // is decided from the frightened value that will be registered when the
    // FSM enters GHOST_SEL for that ghost, so a pellet arriving mid-step
    // affects the ghosts that have not been selected yet.
    always_comb begin
        fright_nxt = fright_cnt;
        if (power_pellet)
            fright_nxt = FR_LOAD;
        else if (state == FINISH && fright_cnt != '0)
            fright_nxt = fright_cnt - FW'(1);

        step_count_nxt = step_count;
        if (state == FINISH) step_count_nxt = step_count + 16'd1;

        ghost_go_nxt = '0;
        if (state_nxt == GHOST_SEL && !((fright_nxt != '0) && step_count[0]))
            ghost_go_nxt[gidx_nxt] = 1'b1;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            gidx        <= '0;
            to_cnt      <= '0;
            fright_cnt  <= '0;
            step_count  <= '0;
            pac_go      <= 1'b0;
            ghost_go    <= '0;
            coll_go     <= 1'b0;
            step_busy   <= 1'b0;
            frightened  <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            gidx        <= gidx_nxt;
            // Every go pulse sits in a non-wait state, so the counter is
            // already zero by the first cycle of each wait.
            to_cnt      <= in_wait ? to_cnt + TW'(1) : '0;
            fright_cnt  <= fright_nxt;
            frightened  <= (fright_nxt != '0);
            step_count  <= step_count_nxt;
            pac_go      <= (state_nxt == PAC_GO);
            ghost_go    <= ghost_go_nxt;
            coll_go     <= (state_nxt == COLL_GO);
            step_busy   <= (state_nxt != IDLE);
            if (game_tick && state != IDLE) overrun <= 1'b1;
            if (to_set) timeout_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_step_sequencer.sv
// Testbench for step_sequencer. A responder answers each go pulse with a
// done after a chosen delay and toggles done lines that the sequencer must
// ignore. A step-level model predicts the go order, the number of busy
// cycles, the counter, the frightened timer and the sticky flags.
module tb_step_sequencer;
    localparam int G  = 4;
    localparam int FR = 16;
    localparam int TO = 1024;

    logic         Clk = 1'b0, Reset = 1'b1;
    logic         game_tick = 1'b0, pause = 1'b0, power_pellet = 1'b0;
    logic         pac_done = 1'b0, coll_done = 1'b0;
    logic [G-1:0] ghost_done = '0;
    logic         pac_go, coll_go, step_busy, frightened, overrun, timeout_err;
    logic [G-1:0] ghost_go;
    logic [15:0]  step_count;

    step_sequencer #(.NUM_GHOSTS(G), .FRIGHT_TICKS(FR), .STEP_TIMEOUT(TO)) dut (
        .Clk(Clk), .Reset(Reset), .game_tick(game_tick), .pause(pause),
        .power_pellet(power_pellet), .pac_done(pac_done), .ghost_done(ghost_done),
        .coll_done(coll_done), .pac_go(pac_go), .ghost_go(ghost_go), .coll_go(coll_go),
        .step_busy(step_busy), .frightened(frightened), .overrun(overrun),
        .timeout_err(timeout_err), .step_count(step_count)
    );

    always #5 Clk = ~Clk;

    int n_vec = 0, n_err = 0, cyc_n = 0;
    int evq[$], evc[$];            // go events seen: code and cycle
    int resp_dly = 3, stuck_g = -1, pend = 0, pend_k = 0, ph = -1;
    int busy_n = 0, multi = 0;
    int m_fright = 0, m_ovr = 0, m_terr = 0;
    logic [15:0] m_steps = '0;

    task automatic chk(input string tag, input int obs, input int expv);
        n_vec++;
        if (obs != expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, expv, cyc_n);
        end
    endtask

    // Go event codes: 0 = pac, 1+i = ghost i, G+1 = collision.
    task automatic log_go(input int k);
        evq.push_back(k);
        evc.push_back(cyc_n);
        ph = k;
        if (!(stuck_g >= 0 && k == stuck_g + 1)) begin
            pend   = resp_dly;
            pend_k = k;
        end
    endtask

    // One clock cycle: observe at the falling edge, then drive the done
    // lines for the remainder of the cycle.
    task automatic cyc();
        int ngo, fk;
        bit fire;
        @(negedge Clk);
        cyc_n++;
        busy_n += int'(step_busy);
        ngo = int'(pac_go) + int'(coll_go) + $countones(ghost_go);
        if (ngo > 1) multi++;
        fire = 1'b0;
        fk   = pend_k;
        if (pend > 0) begin
            pend--;
            fire = (pend == 0);
        end
        if (pac_go) log_go(0);
        for (int i = 0; i < G; i++) if (ghost_go[i]) log_go(1 + i);
        if (coll_go) log_go(G + 1);
        if (!step_busy) ph = -1;
        // Noise only on lines whose unit has already had its turn, or on
        // coll_done before the collision phase.
        pac_done  = (fire && fk == 0) || (ph >= 1 && $urandom_range(0, 1) == 1);
        coll_done = (fire && fk == G + 1) || (ph >= 0 && ph <= G && $urandom_range(0, 1) == 1);
        for (int j = 0; j < G; j++)
            ghost_done[j] = (fire && fk == j + 1) || (j < ph - 1 && $urandom_range(0, 1) == 1);
    endtask

    task automatic chk_state();
        chk("step_count", int'(step_count), int'(m_steps));
        chk("frightened", int'(frightened), int'(m_fright != 0));
        chk("fright_cnt", int'(dut.fright_cnt), m_fright);
        chk("overrun", int'(overrun), m_ovr);
        chk("timeout_err", int'(timeout_err), m_terr);
        chk("idle_busy", int'(step_busy), 0);
    endtask

    task automatic rst_chk();
        chk("rst_pac_go", int'(pac_go), 0);
        chk("rst_ghost_go", int'(ghost_go), 0);
        chk("rst_coll_go", int'(coll_go), 0);
        chk("rst_busy", int'(step_busy), 0);
        chk("rst_fright", int'(frightened), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_timeout", int'(timeout_err), 0);
        chk("rst_count", int'(step_count), 0);
    endtask

    task automatic pellet();
        power_pellet = 1'b1;
        cyc();
        power_pellet = 1'b0;
        m_fright = FR;
    endtask

    // Run one step. d: done delay; stuck: ghost that never answers (-1 none);
    // xtick: extra tick during the first wait after pac; pmid: raise pause
    // mid-step and then try a tick; pel_fin: pellet in the FINISH cycle.
    task automatic do_step(input int d, input int stuck, input bit xtick,
                           input bit pmid, input bit pel_fin);
        int  exp_q[$];
        int  tick_c, n, exp_busy;
        bit  skip, xd;
        xd       = 1'b0;
        resp_dly = d;
        stuck_g  = stuck;
        skip     = (m_fright != 0) && m_steps[0];
        exp_busy = 3 + 2 * d;              // PAC_GO, COLL_GO, FINISH + two waits
        exp_q.push_back(0);
        for (int i = 0; i < G; i++) begin
            if (skip) exp_busy += 1;
            else begin
                exp_q.push_back(1 + i);
                exp_busy += 1 + ((i == stuck) ? TO - 1 : d);
            end
        end
        exp_q.push_back(G + 1);

        evq.delete(); evc.delete(); multi = 0;
        tick_c    = cyc_n;
        game_tick = 1'b1;
        busy_n    = 0;
        cyc();
        game_tick = 1'b0;
        n = 0;
        while (step_busy && n < 5000) begin
            cyc();
            n++;
            game_tick    = 1'b0;
            power_pellet = 1'b0;
            if (xtick && !xd && evq.size() >= 2 && evc[1] == cyc_n - 1) begin
                game_tick = 1'b1;
                xd = 1'b1;
            end
            if (pmid && evq.size() >= 1) pause = 1'b1;
            if (pel_fin && evq.size() > 0 && evq[$] == G + 1 && cyc_n == evc[$] + d + 1)
                power_pellet = 1'b1;
        end
        chk("step_end", int'(n < 5000), 1);
        chk("pac_lat", (evq.size() > 0) ? evc[0] - tick_c : -1, 1);
        chk("seq_len", evq.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < evq.size(); i++) chk("seq", evq[i], exp_q[i]);
        chk("busy_cyc", busy_n, exp_busy);
        chk("one_go", multi, 0);
        if (stuck >= 0 && evq.size() > stuck + 2)
            chk("to_gap", evc[stuck + 2] - evc[stuck + 1], TO);

        m_steps = m_steps + 16'd1;
        if (pel_fin) m_fright = FR;
        else if (m_fright > 0) m_fright--;
        if (xtick) m_ovr = 1;
        if (stuck >= 0) m_terr = 1;
        stuck_g = -1;
        chk_state();

        if (xtick) begin
            evq.delete();
            repeat (4) cyc();
            chk("no_extra", evq.size(), 0);
        end
        if (pmid) begin
            evq.delete();
            game_tick = 1'b1;
            cyc();
            game_tick = 1'b0;
            repeat (4) cyc();
            chk("pause_drop", evq.size(), 0);
            chk("pause_ovr", int'(overrun), m_ovr);
            pause = 1'b0;
            cyc();
        end
    endtask

    initial begin
        int n;
        repeat (3) cyc();
        rst_chk();
        Reset = 1'b0;
        cyc();

        // Nominal step with 3-cycle dones.
        do_step(3, -1, 1'b0, 1'b0, 1'b0);

        // Tick while paused in IDLE is dropped without overrun.
        pause = 1'b1;
        evq.delete();
        game_tick = 1'b1;
        cyc();
        game_tick = 1'b0;
        repeat (4) cyc();
        chk("idle_pause_go", evq.size(), 0);
        chk("idle_pause_ovr", int'(overrun), 0);
        chk("idle_pause_cnt", int'(step_count), int'(m_steps));
        pause = 1'b0;
        cyc();

        do_step(3, -1, 1'b1, 1'b0, 1'b0);  // overrun
        do_step(2, -1, 1'b0, 1'b1, 1'b0);  // pause rises mid-step
        do_step(1, -1, 1'b0, 1'b0, 1'b0);

        // Frightened: 16 steps, ghosts skipped on odd steps.
        pellet();
        repeat (16) do_step($urandom_range(1, 5), -1, 1'b0, 1'b0, 1'b0);

        // Pellet in the FINISH cycle with five steps left wins over the decrement.
        pellet();
        repeat (11) do_step($urandom_range(1, 4), -1, 1'b0, 1'b0, 1'b0);
        chk("fright_at5", int'(dut.fright_cnt), 5);
        do_step(2, -1, 1'b0, 1'b0, 1'b1);

        // Ghost 2 never answers.
        do_step(3, 2, 1'b0, 1'b0, 1'b0);

        // Counter wrap.
        force dut.step_count = 16'hFFFF;
        cyc();
        cyc();
        release dut.step_count;
        m_steps = 16'hFFFF;
        chk("wrap_load", int'(step_count), 16'hFFFF);
        do_step(2, -1, 1'b0, 1'b0, 1'b0);

        // Randomized steps.
        for (int r = 0; r < 25; r++) begin
            if ($urandom_range(0, 3) == 0) pellet();
            do_step($urandom_range(1, 5), -1, $urandom_range(0, 5) == 0,
                    $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0);
        end

        // Reset during COLL_WAIT.
        resp_dly = 8;
        evq.delete(); evc.delete();
        game_tick = 1'b1;
        cyc();
        game_tick = 1'b0;
        n = 0;
        while (!(evq.size() > 0 && evq[$] == G + 1) && n < 500) begin
            cyc();
            n++;
        end
        chk("rst_reach_coll", int'(n < 500), 1);
        cyc();
        cyc();
        #2 Reset = 1'b1;
        #1;
        rst_chk();
        pend = 0;
        ph = -1;
        coll_done = 1'b1;
        cyc();
        cyc();
        Reset = 1'b0;
        m_steps = '0; m_fright = 0; m_ovr = 0; m_terr = 0;
        cyc();
        chk("post_rst_busy", int'(step_busy), 0);
        do_step(3, -1, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
